latch_wr_ctrl: RTL and testbench

- Write-side initiator for banks of gated D latches (pass when wen=1, hold when wen=0).
- Accepts one word-write request at a time over a valid/ready handshake.
- Drives the shared latch data bus and a one-hot, flop-registered (glitch-free) wen.
- Guarantees programmable setup, pulse and hold margins around each wen pulse, then reports completion.

---
 rtl/latch_wr_ctrl.sv | 143 ++++++++++++++
 tb/tb_latch_wr_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/latch_wr_ctrl.sv
// Write-side sequencer for gated D-latch banks: setup / wen pulse / hold around each word write.
// Optional macro LATCH_WR_READBACK_EN adds rb_q and a readback compare folded into done_err.
module latch_wr_ctrl #(
   parameter int DW        = 8,
   parameter int NWORDS    = 4,
   parameter int AW        = 2,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 1,
   parameter int HOLD_CYC  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [AW-1:0]     req_addr,
   input  logic [DW-1:0]     req_data,
   output logic [DW-1:0]     wr_d,
   output logic [NWORDS-1:0] wr_wen,
   output logic              busy,
   output logic              done,
   output logic              done_err
`ifdef LATCH_WR_READBACK_EN
   ,
   input  logic [DW-1:0]     rb_q
`endif
);

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wr_d_q, wr_d_d;
   logic [NWORDS-1:0] wen_q, wen_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              oor;
   logic [NWORDS-1:0] onehot;
   logic              err_flag;

   // An out-of-range address decodes to no enable at all, so the timing runs with wen idle.
   always_comb begin
      oor    = int'(addr_q) >= NWORDS;
      onehot = '0;
      for (int i = 0; i < NWORDS; i++) onehot[i] = (int'(addr_q) == i);
`ifdef LATCH_WR_READBACK_EN
      err_flag = oor || (rb_q != wr_d_q);
`else
      err_flag = oor;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wr_d_d  = wr_d_q;
      wen_d   = wen_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wr_d_d  = req_data;
               cnt_d   = SETUP_LD;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               wen_d   = onehot;
               cnt_d   = PULSE_LD;
               state_d = PULSE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               wen_d   = '0;
               cnt_d   = HOLD_LD;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               done_d  = 1'b1;
               err_d   = err_flag;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Status flags follow the next state so they stay registered.
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_d_q  <= '0;
         wen_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_d_q  <= wr_d_d;
         wen_q   <= wen_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign done_err  = err_q;
   assign wr_d      = wr_d_q;
   assign wr_wen    = wen_q;

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// Randomized bench for latch_wr_ctrl: three configurations checked against an edge-count schedule model.
module tb_latch_wr_ctrl;

   localparam int DW = 8;
   localparam int AW = 2;

   logic clk;
   int   n_chk  = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int S   = (g == 1) ? 3 : (g == 2) ? 2 : 1;
      localparam int P   = (g == 1) ? 2 : 1;
      localparam int H   = (g == 1) ? 2 : (g == 2) ? 3 : 1;
      localparam int NW  = (g == 2) ? 3 : 4;
      localparam int TOT = S + P + H;

      logic          rst_n;
      logic          req_valid;
      logic          req_ready;
      logic [AW-1:0] req_addr;
      logic [DW-1:0] req_data;
      logic [DW-1:0] wr_d;
      logic [NW-1:0] wr_wen;
      logic          busy, done, done_err;
      logic          corrupt;
      bit            fin = 1'b0;

      logic [DW-1:0] mem [NW];
      int            m_k;
      logic [AW-1:0] m_addr;
      logic [DW-1:0] m_d;
      logic [NW-1:0] wen_e;
      logic          done_e, err_e, inr;

`ifdef LATCH_WR_READBACK_EN
      logic [DW-1:0] rb_q;
      assign rb_q = corrupt ? '0 : ((int'(m_addr) < NW) ? mem[m_addr] : '0);
`endif

      latch_wr_ctrl #(
         .DW(DW), .NWORDS(NW), .AW(AW),
         .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
      ) dut (
         .clk(clk), .rst_n(rst_n),
         .req_valid(req_valid), .req_ready(req_ready),
         .req_addr(req_addr), .req_data(req_data),
         .wr_d(wr_d), .wr_wen(wr_wen),
         .busy(busy), .done(done), .done_err(done_err)
`ifdef LATCH_WR_READBACK_EN
         , .rb_q(rb_q)
`endif
      );

      // Latch bank behaviour: transparent while its enable is high.
      always_latch
         for (int i = 0; i < NW; i++)
            if (wr_wen[i]) mem[i] <= wr_d;

      // Model: m_k = edges since the accept edge; TOT+1 means idle.
      always @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            m_k <= TOT + 1; m_d <= '0; m_addr <= '0;
         end else if (m_k <= TOT) begin
            m_k <= m_k + 1;
         end else if (req_valid) begin
            m_k <= 0; m_addr <= req_addr; m_d <= req_data;
         end

      always_comb begin
         inr    = int'(m_addr) < NW;
         wen_e  = '0;
         if (m_k >= S && m_k < S + P && inr) wen_e[m_addr] = 1'b1;
         done_e = (m_k == TOT);
`ifdef LATCH_WR_READBACK_EN
         err_e  = done_e && (!inr || (corrupt && m_d != '0));
`else
         err_e  = done_e && !inr;
`endif
      end

      function automatic string t(input string s);
         return $sformatf("g%0d_%s", g, s);
      endfunction

      always @(negedge clk)
         if (rst_n) begin
            chk(t("wen"), 32'(wr_wen), 32'(wen_e));
            chk(t("wr_d"), 32'(wr_d), 32'(m_d));
            chk(t("busy"), 32'(busy), 32'(m_k <= TOT));
            chk(t("ready"), 32'(req_ready), 32'(m_k > TOT));
            chk(t("done"), 32'(done), 32'(done_e));
            chk(t("done_err"), 32'(done_err), 32'(err_e));
            if (done_e && inr) chk(t("latch"), 32'(mem[m_addr]), 32'(m_d));
         end

      task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
         bit got;
         got = 1'b0;
         req_valid = 1'b1; req_addr = a; req_data = d;
         for (int n = 0; n < 64 && !got; n++) begin
            got = req_ready;
            @(negedge clk);
         end
         if (!keep) req_valid = 1'b0;
         if (!got) chk(t("accept_timeout"), 32'(got), 32'd1);
      endtask

      task automatic wait_idle();
         int n;
         n = 0;
         while (!req_ready && n < 64) begin @(negedge clk); n++; end
         if (!req_ready) chk(t("idle_timeout"), 32'(req_ready), 32'd1);
      endtask

      task automatic chk_reset(input string s);
         chk(t({s, "_wen"}), 32'(wr_wen), 32'd0);
         chk(t({s, "_wr_d"}), 32'(wr_d), 32'd0);
         chk(t({s, "_ready"}), 32'(req_ready), 32'd1);
         chk(t({s, "_busy"}), 32'(busy), 32'd0);
         chk(t({s, "_done"}), 32'(done), 32'd0);
         chk(t({s, "_done_err"}), 32'(done_err), 32'd0);
      endtask

      initial begin : drv
         int n;
         rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; corrupt = 1'b0;
         repeat (3) @(negedge clk);
         chk_reset("rst");
         rst_n = 1'b1;
         @(negedge clk);
         chk_reset("idle");

         send((g == 2) ? 2'd3 : (g == 1) ? 2'd0 : 2'd2, (g == 1) ? 8'h3C : 8'hA5, 1'b0);
         wait_idle();
         send(2'd1, 8'h11, 1'b1);
         send(2'd3, 8'hEE, 1'b0);
         wait_idle();
`ifdef LATCH_WR_READBACK_EN
         corrupt = 1'b1;
         send(2'd1, 8'hFF, 1'b0);
         wait_idle();
         corrupt = 1'b0;
`endif
         repeat (30) begin
            send(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         req_valid = 1'b0;
         wait_idle();

         // Abort mid-pulse, then confirm a fresh write still completes.
         send(2'd0, 8'h5A, 1'b0);
         n = 0;
         while (wr_wen == '0 && n < 32) begin @(negedge clk); n++; end
         chk(t("pulse_seen"), 32'(wr_wen != '0), 32'd1);
         #1 rst_n = 1'b0;
         #1 chk_reset("abort");
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         send(2'd2, 8'hC3, 1'b0);
         wait_idle();
         fin = 1'b1;
      end
   end

   initial begin : main
      int n;
      n = 0;
      while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && n < 30000) begin
         @(negedge clk); n++;
      end
      chk("all_finished", 32'(cfg[0].fin && cfg[1].fin && cfg[2].fin), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
